// File: rtl/io_bridge_pkg.sv
// Shared constants and types for the CPU I/O bridge: I/O page decode,
// mapped register addresses, read-select and stop-FSM encodings.
package io_bridge_pkg;

    localparam logic [1:0]  IO_PAGE  = 2'b11;
    localparam logic [17:0] ADDR_RX  = 18'h30000;
    localparam logic [17:0] ADDR_CNT = 18'h30004;

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_RX   = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOPPING = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// Bus bundle between the CPU core, the RAM, the UART queues and io_bridge.
// slave: the bridge side; master: the environment (core, RAM, UART) side.
interface io_bridge_if #(
    parameter int RAM_AW = 17
) ();

    logic              rdy_in;
    logic [31:0]       cpu_a;
    logic              cpu_wr;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              io_buffer_full;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_pop;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              prog_done;

    modport slave (
        input  rdy_in, cpu_a, cpu_wr, cpu_dout, ram_rdata, rx_data, rx_valid, tx_ready,
        output cpu_din, io_buffer_full, ram_a, ram_we, ram_wdata, rx_pop, tx_data, tx_valid,
               prog_done
    );

    modport master (
        output rdy_in, cpu_a, cpu_wr, cpu_dout, ram_rdata, rx_data, rx_valid, tx_ready,
        input  cpu_din, io_buffer_full, ram_a, ram_we, ram_wdata, rx_pop, tx_data, tx_valid,
               prog_done
    );

endinterface

// File: rtl/io_bridge_fifo.sv
// Synchronous FIFO for outgoing UART bytes. Push into a full FIFO is dropped
// and latches a sticky overflow flag, unless a pop happens in the same cycle.
module io_fifo #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     head,
    output logic [DEPTH_LOG:0]   count,
    output logic [DEPTH_LOG:0]   count_next,
    output logic                 empty,
    output logic                 full
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 push_ok, pop_ok;

    // Accept/reject decisions, pointer and occupancy updates.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG'(push_ok);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG'(pop_ok);
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        overflow_d = overflow_q || (push && !push_ok);
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/io_bridge.sv
// CPU memory-bus endpoint: RAM/I-O decode, one-cycle read mux, free-running
// cycle counter with coherent snapshot, UART TX queue and RUN/STOPPING/DONE FSM.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2,
    parameter int RAM_AW       = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    io_bridge_if.slave  bus
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG;
    localparam int CW    = TX_DEPTH_LOG + 1;

    logic [17:0] addr;
    logic        is_io, hit_rx, hit_cnt;
    logic        rd_rx, rd_cnt0, wr_tx, wr_stop;
    logic        fifo_push, fifo_pop;
    logic [7:0]  fifo_din, fifo_head;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic        fifo_empty, fifo_full;
    logic [7:0]  rd_mux;
    logic        unused_ok;

    sel_e        sel_q, sel_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] cnt_q, cnt_d;
    logic        full_q, full_d;
    state_e      state_q, state_d;

    assign addr = bus.cpu_a[17:0];

    // Address decode and access qualification.
    always_comb begin
        is_io     = (addr[17:16] == IO_PAGE);
        hit_rx    = (addr == ADDR_RX);
        hit_cnt   = (addr[17:2] == ADDR_CNT[17:2]);
        rd_rx     = bus.rdy_in && !bus.cpu_wr && hit_rx;
        rd_cnt0   = bus.rdy_in && !bus.cpu_wr && (addr == ADDR_CNT);
        wr_tx     = bus.rdy_in && bus.cpu_wr && hit_rx;
        wr_stop   = bus.rdy_in && bus.cpu_wr && (addr == ADDR_CNT);
        // The stop marker is the only 0x00 that can enter the queue.
        fifo_push = (wr_tx && (bus.cpu_dout != 8'h00)) || wr_stop;
        fifo_din  = wr_stop ? 8'h00 : bus.cpu_dout;
        fifo_pop  = !fifo_empty && bus.tx_ready;
    end

    // Read-pipeline, RX latch, counter/snapshot and near-full next values.
    always_comb begin
        sel_d     = sel_q;
        lane_d    = lane_q;
        rx_byte_d = rx_byte_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q + 32'd1;
        full_d    = ((CW'(DEPTH) - fifo_count_next) <= CW'(FULL_MARGIN));
        if (bus.rdy_in) begin
            lane_d = addr[1:0];
            if (!is_io) begin
                sel_d = SEL_RAM;
            end else if (hit_rx) begin
                sel_d = SEL_RX;
            end else if (hit_cnt) begin
                sel_d = SEL_CNT;
            end else begin
                sel_d = SEL_NONE;
            end
        end
        if (rd_rx) begin
            rx_byte_d = bus.rx_valid ? bus.rx_data : 8'h00;
        end
        if (rd_cnt0) begin
            snap_d = cnt_q;
        end
    end

    // Stop sequencing: DONE once the marker (the only queued 0x00) leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (wr_stop) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (fifo_pop && (fifo_head == 8'h00)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    // Registered state with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_q     <= SEL_RAM;
            lane_q    <= '0;
            rx_byte_q <= '0;
            snap_q    <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            sel_q     <= sel_d;
            lane_q    <= lane_d;
            rx_byte_q <= rx_byte_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            state_q   <= state_d;
        end
    end

    // Read data mux, one cycle after the access.
    always_comb begin
        rd_mux = 8'h00;
        case (sel_q)
            SEL_RAM: rd_mux = bus.ram_rdata;
            SEL_RX:  rd_mux = rx_byte_q;
            SEL_CNT: rd_mux = byte_lane(snap_q, lane_q);
            default: rd_mux = 8'h00;
        endcase
    end

    io_fifo #(
        .DEPTH_LOG (TX_DEPTH_LOG),
        .WIDTH     (8)
    ) u_fifo (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .din        (fifo_din),
        .head       (fifo_head),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Combinational outputs are forced low while reset is held.
    assign bus.ram_we         = rst_in && bus.rdy_in && bus.cpu_wr && !is_io;
    assign bus.ram_a          = rst_in ? bus.cpu_a[RAM_AW-1:0] : '0;
    assign bus.ram_wdata      = rst_in ? bus.cpu_dout : '0;
    assign bus.rx_pop         = rst_in && rd_rx && bus.rx_valid;
    assign bus.cpu_din        = rst_in ? rd_mux : '0;
    assign bus.tx_valid       = !fifo_empty;
    assign bus.tx_data        = fifo_empty ? 8'h00 : fifo_head;
    assign bus.io_buffer_full = full_q;
    assign bus.prog_done      = (state_q == ST_DONE);

    assign unused_ok = ^{bus.cpu_a[31:18], fifo_count, fifo_full};

endmodule
